// File: rtl/led_seq_pkg.sv
// Shared types and field layout for the LED pattern sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WORD_W    = 32;
  localparam int PAT_LSB   = 0;
  localparam int DWELL_LSB = 8;
  localparam int DWELL_W   = 16;
  localparam int DUTY_LSB  = 24;
  localparam int DUTY_W    = 8;

  localparam int ST_BUSY_BIT = 0;
  localparam int ST_DONE_BIT = 1;
  localparam int ST_STEP_LSB = 4;

  function automatic logic [WORD_W-1:0] pack_status(input logic [2:0] step,
                                                    input logic       sticky,
                                                    input logic       busy);
    logic [WORD_W-1:0] s;
    s = '0;
    s[ST_STEP_LSB +: 3] = step;
    s[ST_DONE_BIT]      = sticky;
    s[ST_BUSY_BIT]      = busy;
    return s;
  endfunction

endpackage

// File: rtl/led_seq_ctrl_tick_gen.sv
// Prescaler for the LED sequencer: counts 0..terminal while enabled, ticking on terminal count.
module led_tick_gen #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] terminal,
  output logic         tick
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == terminal);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: steps through up to 8 table words, each held for a dwell time.
// Optional PWM dimming from the per-step duty field when LED_PWM_EN is defined.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int LED_WIDTH          = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_STEPS          = 8,
  parameter int PRESCALE_W         = 16
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    ctrl_start,
  input  logic                                    ctrl_stop,
  input  logic                                    cfg_loop,
  input  logic [2:0]                              cfg_len,
  input  logic [PRESCALE_W-1:0]                   cfg_prescale,
  input  logic [NUM_STEPS*C_S_AXI_DATA_WIDTH-1:0] pat_tbl,
  output logic [LED_WIDTH-1:0]                    led,
  output logic                                    busy,
  output logic                                    done,
  output logic [C_S_AXI_DATA_WIDTH-1:0]           status
);

  state_t                 state_q, state_d;
  logic [2:0]             step_q, step_d;
  logic [2:0]             len_q, len_d;
  logic                   loop_q, loop_d;
  logic [PRESCALE_W-1:0]  prescale_q, prescale_d;
  logic [DWELL_W-1:0]     dwell_q, dwell_d;
  logic [LED_WIDTH-1:0]   pat_q, pat_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   sticky_q, sticky_d;

  logic                   start_s;
  logic                   tick_s;
  logic                   load_s;
  logic [2:0]             load_idx_s;
  int                     load_base_s;

  assign start_s     = ctrl_start && !ctrl_stop && (state_q == IDLE);
  assign load_base_s = int'(load_idx_s) * C_S_AXI_DATA_WIDTH;

  led_tick_gen #(.W(PRESCALE_W)) u_tick (
    .clk      (clk),
    .rst      (reset),
    .clear    (start_s),
    .en       (state_q == SHOW),
    .terminal (prescale_q),
    .tick     (tick_s)
  );

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    len_d      = len_q;
    loop_d     = loop_q;
    prescale_d = prescale_q;
    dwell_d    = dwell_q;
    pat_d      = pat_q;
    sticky_d   = sticky_q;
    load_s     = 1'b0;
    load_idx_s = step_q;

    case (state_q)
      IDLE: begin
        if (ctrl_stop) begin
          pat_d = '0;
        end else if (ctrl_start) begin
          state_d    = SHOW;
          len_d      = cfg_len;
          loop_d     = cfg_loop;
          prescale_d = cfg_prescale;
          sticky_d   = 1'b0;
          load_s     = 1'b1;
          load_idx_s = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      SHOW: begin
        if (ctrl_stop) begin
          state_d = IDLE;
          pat_d   = '0;
        end else if (tick_s && (dwell_q <= 16'd1)) begin
          // A dwell of 0 falls into this branch too, so it behaves like 1.
          if (step_q != len_q) begin
            load_s     = 1'b1;
            load_idx_s = step_q + 3'd1;
          end else if (loop_q) begin
            load_s     = 1'b1;
            load_idx_s = 3'd0;
          end else begin
            state_d  = DONE;
            sticky_d = 1'b1;
          end
        end else if (tick_s) begin
          dwell_d = dwell_q - 16'd1;
        end else begin
          dwell_d = dwell_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (ctrl_stop) begin
          pat_d = '0;
        end else begin
          pat_d = pat_q;
        end
      end
      default: begin
        state_d = IDLE;
        pat_d   = '0;
      end
    endcase

    if (load_s) begin
      step_d  = load_idx_s;
      pat_d   = pat_tbl[load_base_s + PAT_LSB +: LED_WIDTH];
      dwell_d = pat_tbl[load_base_s + DWELL_LSB +: DWELL_W];
    end else begin
      step_d = step_q;
    end

    busy_d = (state_d == SHOW);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      step_q     <= 3'd0;
      len_q      <= 3'd0;
      loop_q     <= 1'b0;
      prescale_q <= '0;
      dwell_q    <= '0;
      pat_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      len_q      <= len_d;
      loop_q     <= loop_d;
      prescale_q <= prescale_d;
      dwell_q    <= dwell_d;
      pat_q      <= pat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sticky_q   <= sticky_d;
    end
  end

`ifdef LED_PWM_EN
  logic [DUTY_W-1:0]    duty_q, duty_d;
  logic [DUTY_W-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic [LED_WIDTH-1:0] led_q, led_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    if (load_s) duty_d = pat_tbl[load_base_s + DUTY_LSB +: DUTY_W];
    else        duty_d = duty_q;
    led_d = pat_d & {LED_WIDTH{pwm_cnt_d < duty_d}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_q    <= '0;
      pwm_cnt_q <= '0;
      led_q     <= '0;
    end else begin
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
    end
  end

  assign led = led_q;
`else
  assign led = pat_q;
`endif

  assign busy   = busy_q;
  assign done   = done_q;
  assign status = C_S_AXI_DATA_WIDTH'(pack_status(step_q, sticky_q, busy_q));

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed self-checking bench for led_seq_ctrl (PWM section runs only with LED_PWM_EN).
module tb_led_seq_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         ctrl_start, ctrl_stop, cfg_loop;
  logic [2:0]   cfg_len;
  logic [15:0]  cfg_prescale;
  logic [255:0] pat_tbl;
  logic [3:0]   led;
  logic         busy, done;
  logic [31:0]  status;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_seq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .ctrl_start   (ctrl_start),
    .ctrl_stop    (ctrl_stop),
    .cfg_loop     (cfg_loop),
    .cfg_len      (cfg_len),
    .cfg_prescale (cfg_prescale),
    .pat_tbl      (pat_tbl),
    .led          (led),
    .busy         (busy),
    .done         (done),
    .status       (status)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ctrl_start = 1'b0;
    ctrl_stop  = 1'b0;
    reset      = 1'b1;
    step_clk();
    reset = 1'b0;
  endtask

  task automatic set_word(input int k, input logic [3:0] p, input logic [15:0] d, input logic [7:0] du);
    pat_tbl[32*k +: 32] = {du, d, 4'h0, p};
  endtask

  task automatic pulse_start();
    ctrl_start = 1'b1;
    step_clk();
    ctrl_start = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_led1 [8];
    logic       exp_done1[8];
    logic       exp_busy1[8];
    int         done_cnt;
    int         on_cnt;

    exp_led1  = '{4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4};
    exp_done1 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_busy1 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    pat_tbl      = 256'd0;
    cfg_loop     = 1'b0;
    cfg_len      = 3'd0;
    cfg_prescale = 16'd0;
    do_reset();

    check_val("reset_led",    {28'd0, led}, 32'd0);
    check_val("reset_busy",   {31'd0, busy}, 32'd0);
    check_val("reset_done",   {31'd0, done}, 32'd0);
    check_val("reset_status", status, 32'd0);

    // 1: one-shot, three steps with dwells 1/2/3
    set_word(0, 4'h1, 16'd1, 8'd0);
    set_word(1, 4'h2, 16'd2, 8'd0);
    set_word(2, 4'h4, 16'd3, 8'd0);
    cfg_prescale = 16'd0;
    cfg_len      = 3'd2;
    cfg_loop     = 1'b0;
    pulse_start();
    done_cnt = 0;
    check_val("t1_status_start", status, 32'h0000_0001);
    for (int k = 0; k < 8; k++) begin
      check_val($sformatf("t1_led_%0d", k),  {28'd0, led},  {28'd0, exp_led1[k]});
      check_val($sformatf("t1_done_%0d", k), {31'd0, done}, {31'd0, exp_done1[k]});
      check_val($sformatf("t1_busy_%0d", k), {31'd0, busy}, {31'd0, exp_busy1[k]});
      if (k == 3) check_val("t1_status_step2", status, 32'h0000_0021);
      if (done) done_cnt++;
      step_clk();
    end
    for (int k = 0; k < 10; k++) begin
      if (done) done_cnt++;
      step_clk();
    end
    check_val("t1_done_count", 32'(done_cnt), 32'd1);
    check_val("t1_status_end", status, 32'h0000_0022);
    check_val("t1_led_hold",   {28'd0, led}, 32'h4);

    // 2: prescale 3, single looping step, then two looping steps
    do_reset();
    set_word(0, 4'h5, 16'd2, 8'd0);
    set_word(1, 4'hA, 16'd1, 8'd0);
    cfg_prescale = 16'd3;
    cfg_len      = 3'd0;
    cfg_loop     = 1'b1;
    pulse_start();
    for (int k = 0; k < 20; k++) begin
      if (k % 5 == 0) begin
        check_val($sformatf("t2a_led_%0d", k), {28'd0, led}, 32'h5);
        check_val($sformatf("t2a_status_%0d", k), status, 32'h0000_0001);
      end
      step_clk();
    end
    do_reset();
    set_word(0, 4'h5, 16'd1, 8'd0);
    cfg_len = 3'd1;
    pulse_start();
    cfg_prescale = 16'd0;
    for (int k = 0; k < 12; k++) begin
      check_val($sformatf("t2b_led_%0d", k), {28'd0, led},
                (((k / 4) % 2) == 0) ? 32'h5 : 32'hA);
      step_clk();
    end

    // 3: start+stop together, then stop during step 1
    do_reset();
    cfg_prescale = 16'd0;
    cfg_len      = 3'd2;
    cfg_loop     = 1'b0;
    set_word(0, 4'h1, 16'd1, 8'd0);
    set_word(1, 4'h2, 16'd2, 8'd0);
    set_word(2, 4'h4, 16'd3, 8'd0);
    ctrl_start = 1'b1;
    ctrl_stop  = 1'b1;
    step_clk();
    ctrl_start = 1'b0;
    ctrl_stop  = 1'b0;
    check_val("t3_both_busy", {31'd0, busy}, 32'd0);
    check_val("t3_both_led",  {28'd0, led},  32'd0);
    step_clk();
    check_val("t3_both_busy2", {31'd0, busy}, 32'd0);
    pulse_start();
    step_clk();
    check_val("t3_step1_led", {28'd0, led}, 32'h2);
    ctrl_stop = 1'b1;
    step_clk();
    ctrl_stop = 1'b0;
    check_val("t3_stop_led",  {28'd0, led},  32'd0);
    check_val("t3_stop_busy", {31'd0, busy}, 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) done_cnt++;
      step_clk();
    end
    check_val("t3_no_done",     32'(done_cnt), 32'd0);
    check_val("t3_status_bits", {30'd0, status[1:0]}, 32'd0);

    // 4: all dwells zero, eight steps looping; a start mid-run is ignored
    do_reset();
    for (int k = 0; k < 8; k++) set_word(k, 4'(k + 1), 16'd0, 8'd0);
    cfg_len  = 3'd7;
    cfg_loop = 1'b1;
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      check_val($sformatf("t4_led_%0d", k), {28'd0, led}, 32'((k % 8) + 1));
      check_val($sformatf("t4_status_%0d", k), status, 32'(((k % 8) << 4) | 1));
      ctrl_start = (k == 3);
      step_clk();
      ctrl_start = 1'b0;
    end

    // 5: asynchronous reset between edges
    step_clk();
    #2;
    reset = 1'b1;
    #1;
    check_val("t5_led",    {28'd0, led},  32'd0);
    check_val("t5_busy",   {31'd0, busy}, 32'd0);
    check_val("t5_status", status, 32'd0);
    check_val("t5_done",   {31'd0, done}, 32'd0);
    reset = 1'b0;

`ifdef LED_PWM_EN
    // 6: duty 64 gives 64 of every 256 clocks lit; duty 0 stays dark
    do_reset();
    set_word(0, 4'hF, 16'hFFFF, 8'd64);
    cfg_len  = 3'd0;
    cfg_loop = 1'b1;
    pulse_start();
    on_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      if (led == 4'hF) on_cnt++;
      step_clk();
    end
    check_val("t6_duty64", 32'(on_cnt), 32'd64);
    do_reset();
    set_word(0, 4'hF, 16'hFFFF, 8'd0);
    pulse_start();
    on_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      if (led != 4'h0) on_cnt++;
      step_clk();
    end
    check_val("t6_duty0", 32'(on_cnt), 32'd0);
`else
    on_cnt = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
